// File: rtl/net_bus_rx_arb.sv
// net_bus_rx_arb: N-port receive-side frame arbiter.
// Collects beats from one granted input port at a time and forwards them
// through a single registered output stage until the end-of-frame beat.
// The grant is held for the whole frame.
//
// Ports:
//   RCLK      in   1         sole clock, rising edge
//   RESET     in   1         synchronous active-high reset
//   IDATA     in   N*W       flattened input beats, port i at [i*W +: W]
//   IVALID    in   N         per-port beat valid
//   IFRAME    in   N         per-port "complete frame buffered" flag
//   IREADY    out  N         per-port ready, at most one bit high
//   ODATA     out  W         registered output beat (bit 0 = EOF)
//   OVALID    out  1         output beat valid
//   OREADY    in   1         downstream ready
//   GRANT_ID  out  IW        currently / most recently granted port
//   BUSY      out  1         high while a frame is being forwarded
module net_bus_rx_arb #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_PORTS = 4,
    parameter int ARB_MODE = 1,
    parameter logic [NUM_PORTS-1:0] RT_MASK = {NUM_PORTS{1'b0}},
    localparam int W = DATA_WIDTH * 9 + 14,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic                   RCLK,
    input  logic                   RESET,
    input  logic [NUM_PORTS*W-1:0] IDATA,
    input  logic [NUM_PORTS-1:0]   IVALID,
    input  logic [NUM_PORTS-1:0]   IFRAME,
    output logic [NUM_PORTS-1:0]   IREADY,
    output logic [W-1:0]           ODATA,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [IW-1:0]          GRANT_ID,
    output logic                   BUSY
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          rr_last_q, rr_last_d;
    logic [W-1:0]           odata_q, odata_d;
    logic                   ovalid_q, ovalid_d;

    logic [NUM_PORTS-1:0]   elig_s;
    logic [NUM_PORTS-1:0]   iready_s;
    logic [IW-1:0]          winner_s;
    logic [IW:0]            rr_idx_s;
    logic [W-1:0]           sel_beat_s;
    logic                   any_elig_s;
    logic                   accept_s;

    // Real-time ports compete on a single valid beat, others only once a whole frame is buffered.
    assign elig_s     = (RT_MASK & IVALID) | (~RT_MASK & IFRAME);
    assign any_elig_s = |elig_s;
    assign sel_beat_s = IDATA[int'(grant_q) * W +: W];

    // Winner selection: the loops run from lowest to highest priority so the last hit sticks.
    always_comb begin
        winner_s = {IW{1'b0}};
        rr_idx_s = {(IW + 1){1'b0}};
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                winner_s = elig_s[i] ? IW'(i) : winner_s;
            end
        end else begin
            // Offset k = NUM_PORTS lands back on the last granted port: lowest priority.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                rr_idx_s = {1'b0, rr_last_q} + (IW + 1)'(k);
                rr_idx_s = (rr_idx_s >= (IW + 1)'(NUM_PORTS)) ?
                           rr_idx_s - (IW + 1)'(NUM_PORTS) : rr_idx_s;
                winner_s = elig_s[rr_idx_s[IW-1:0]] ? rr_idx_s[IW-1:0] : winner_s;
            end
        end
    end

    // Ready only toward the granted port, only when the output slot frees, never in reset.
    always_comb begin
        iready_s = {NUM_PORTS{1'b0}};
        if ((state_q == ST_BUSY) && !RESET) begin
            iready_s[grant_q] = ~ovalid_q | OREADY;
        end else begin
            iready_s = {NUM_PORTS{1'b0}};
        end
    end

    assign accept_s = IVALID[grant_q] & iready_s[grant_q];

    // Next-state, grant latch and output register update.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;

        case (state_q)
            ST_IDLE: begin
                if (any_elig_s) begin
                    state_d   = ST_BUSY;
                    grant_d   = winner_s;
                    rr_last_d = winner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && sel_beat_s[0]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load wins over a drain; a drain alone empties the slot but keeps the data.
        if (accept_s) begin
            odata_d  = sel_beat_s;
            ovalid_d = 1'b1;
        end else if (OREADY) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State and datapath registers; reset leaves port 0 as the next round-robin favourite.
    always_ff @(posedge RCLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= {IW{1'b0}};
            rr_last_q <= IW'(NUM_PORTS - 1);
            odata_q   <= {W{1'b0}};
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign IREADY   = iready_s;
    assign ODATA    = odata_q;
    assign OVALID   = ovalid_q;
    assign GRANT_ID = grant_q;
    assign BUSY     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_net_bus_rx_arb.sv
// Bench for net_bus_rx_arb. Two instances share one clock:
//   dut 0: round-robin, port 2 real-time
//   dut 1: fixed priority, no real-time ports
// Per-port source queues feed beats; expected output beats (with the port
// they must come from) are queued when stimulus is loaded, and a separate
// monitor pops one entry per output transfer.
module tb_net_bus_rx_arb;
    localparam int NP = 4;
    localparam int W  = 4 * 9 + 14;
    localparam int IW = 2;
    localparam int ND = 2;

    typedef struct packed {
        logic [3:0]   port;
        logic [W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst    [ND];
    logic [NP*W-1:0]   idata  [ND];
    logic [NP-1:0]     ivalid [ND];
    logic [NP-1:0]     iframe [ND];
    logic [NP-1:0]     iready [ND];
    logic [W-1:0]      odata  [ND];
    logic              ovalid [ND];
    logic              oready [ND];
    logic              busy   [ND];
    logic [IW-1:0]     grant  [ND];

    logic [W-1:0]      src_q [ND*NP][$];
    exp_t              exp_q [ND][$];
    logic              oready_pat [ND][$];
    logic [NP-1:0]     iframe_en [ND];
    int                acc_cnt [ND*NP];
    int                busy_cnt [ND];
    logic              prev_stall [ND];
    logic [W-1:0]      prev_data [ND];
    int                checks = 0;
    int                failures = 0;

    net_bus_rx_arb #(.DATA_WIDTH(4), .NUM_PORTS(NP), .ARB_MODE(1), .RT_MASK(4'b0100)) u_rr (
        .RCLK(clk), .RESET(rst[0]), .IDATA(idata[0]), .IVALID(ivalid[0]),
        .IFRAME(iframe[0]), .IREADY(iready[0]), .ODATA(odata[0]), .OVALID(ovalid[0]),
        .OREADY(oready[0]), .GRANT_ID(grant[0]), .BUSY(busy[0])
    );

    net_bus_rx_arb #(.DATA_WIDTH(4), .NUM_PORTS(NP), .ARB_MODE(0), .RT_MASK(4'b0000)) u_fx (
        .RCLK(clk), .RESET(rst[1]), .IDATA(idata[1]), .IVALID(ivalid[1]),
        .IFRAME(iframe[1]), .IREADY(iready[1]), .ODATA(odata[1]), .OVALID(ovalid[1]),
        .OREADY(oready[1]), .GRANT_ID(grant[1]), .BUSY(busy[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(int d, string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL dut%0d %s actual=%0h required=%0h", d, name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk_beat(int tag, int p, int k, int n);
        logic [W-1:0] b;
        b = {W{1'b0}};
        b[W-1:W-32] = 32'hA500_0000 ^ (32'(tag) << 16) ^ (32'(p) << 8) ^ 32'(k);
        b[16:1] = 16'(tag * 37 + k * 5 + p);
        b[0] = (k == n - 1);
        return b;
    endfunction

    task automatic load_src(int d, int p, int n, int tag);
        for (int k = 0; k < n; k++) src_q[d*NP+p].push_back(mk_beat(tag, p, k, n));
    endtask

    // Expect the first cnt beats of an n-beat frame from port p.
    task automatic push_exp(int d, int p, int n, int tag, int cnt);
        exp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.port = 4'(p);
            e.data = mk_beat(tag, p, k, n);
            exp_q[d].push_back(e);
        end
    endtask

    task automatic drive();
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[d*NP+p].size() > 0) begin
                    ivalid[d][p] = 1'b1;
                    idata[d][p*W +: W] = src_q[d*NP+p][0];
                end else begin
                    ivalid[d][p] = 1'b0;
                    idata[d][p*W +: W] = {W{1'b0}};
                end
                iframe[d][p] = ivalid[d][p] & iframe_en[d][p];
            end
            oready[d] = (oready_pat[d].size() > 0) ? oready_pat[d].pop_front() : 1'b1;
        end
    endtask

    // One clock: sample handshakes at the falling edge, retire accepted beats after the rising edge.
    task automatic step();
        logic [NP-1:0] acc [ND];
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            acc[d] = ivalid[d] & iready[d];
            chk(d, "iready_onehot0", 64'($onehot0(iready[d])), 64'd1);
            if (rst[d]) chk(d, "iready_in_reset", 64'(iready[d]), 64'd0);
            else if (ovalid[d] && !oready[d]) chk(d, "iready_stalled", 64'(iready[d]), 64'd0);
            if (busy[d]) busy_cnt[d]++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                if (acc[d][p] && !rst[d]) begin
                    void'(src_q[d*NP+p].pop_front());
                    acc_cnt[d*NP+p]++;
                end
            end
        end
        drive();
    endtask

    function automatic bit drained(int d);
        bit e;
        e = (exp_q[d].size() == 0) && !busy[d] && !ovalid[d];
        for (int p = 0; p < NP; p++) e = e && (src_q[d*NP+p].size() == 0);
        return e;
    endfunction

    task automatic wait_drain(int d, int budget, string name);
        int n;
        n = 0;
        while (!drained(d) && n < budget) begin
            step();
            n++;
        end
        chk(d, name, 64'(drained(d)), 64'd1);
    endtask

    // Output-side scoreboard: one expected entry per transfer, plus stall stability.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst[d] !== 1'b0) begin
                prev_stall[d] = 1'b0;
            end else begin
                if (prev_stall[d]) begin
                    chk(d, "stall_hold_valid", 64'(ovalid[d]), 64'd1);
                    chk(d, "stall_hold_data", 64'(odata[d]), 64'(prev_data[d]));
                end
                if (ovalid[d] && oready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d unexpected_beat actual=%0h required=none", d, odata[d]);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        chk(d, "beat_data", 64'(odata[d]), 64'(e.data));
                        chk(d, "beat_grant", 64'(grant[d]), 64'(e.port));
                    end
                end
                prev_stall[d] = ovalid[d] & ~oready[d];
                prev_data[d]  = odata[d];
            end
        end
    end

    initial begin
        int n;
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1;
            iframe_en[d] = 4'b1111;
            busy_cnt[d] = 0;
            prev_stall[d] = 1'b0;
            prev_data[d] = {W{1'b0}};
        end
        for (int i = 0; i < ND*NP; i++) acc_cnt[i] = 0;
        drive();
        step();
        step();
        for (int d = 0; d < ND; d++) begin
            chk(d, "reset_ovalid", 64'(ovalid[d]), 64'd0);
            chk(d, "reset_busy", 64'(busy[d]), 64'd0);
            chk(d, "reset_grant", 64'(grant[d]), 64'd0);
            chk(d, "reset_odata", 64'(odata[d]), 64'd0);
            rst[d] = 1'b0;
        end

        // Fixed priority: frames on ports 1 and 3, port 1 first.
        load_src(1, 1, 3, 1);
        load_src(1, 3, 3, 2);
        push_exp(1, 1, 3, 1, 3);
        push_exp(1, 3, 3, 2, 3);

        // Round-robin: two 2-beat frames on every port, order 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                load_src(0, p, 2, 10 + r);
                push_exp(0, p, 2, 10 + r, 2);
            end
        end
        drive();
        wait_drain(0, 200, "rr_drain");
        wait_drain(1, 200, "fixed_drain");

        // Single-beat frames on ports 0 and 1: one busy cycle each.
        busy_cnt[0] = 0;
        load_src(0, 0, 1, 20);
        load_src(0, 1, 1, 21);
        push_exp(0, 0, 1, 20, 1);
        push_exp(0, 1, 1, 21, 1);
        drive();
        wait_drain(0, 50, "single_drain");
        chk(0, "single_busy_cycles", 64'(busy_cnt[0]), 64'd2);

        // Backpressure during a 4-beat frame.
        load_src(0, 0, 4, 30);
        push_exp(0, 0, 4, 30, 4);
        oready_pat[0].push_back(1'b1);
        oready_pat[0].push_back(1'b1);
        oready_pat[0].push_back(1'b0);
        oready_pat[0].push_back(1'b0);
        oready_pat[0].push_back(1'b1);
        drive();
        wait_drain(0, 50, "stall_drain");

        // Real-time port 2 granted on IVALID; port 1 has IVALID but no IFRAME.
        iframe_en[0] = 4'b0000;
        load_src(0, 2, 3, 40);
        push_exp(0, 2, 3, 40, 3);
        load_src(0, 1, 2, 41);
        drive();
        n = 0;
        while (!(exp_q[0].size() == 0 && !busy[0] && !ovalid[0]) && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) step();
        chk(0, "rt_grant", 64'(grant[0]), 64'd2);
        chk(0, "rt_port1_untouched", 64'(src_q[1].size()), 64'd2);
        chk(0, "rt_idle", 64'(busy[0]), 64'd0);
        src_q[1].delete();
        iframe_en[0] = 4'b1111;
        drive();

        // Reset at beat 2 of a 5-beat frame on port 2; port 0 must then beat port 3.
        acc_cnt[2] = 0;
        load_src(0, 2, 5, 50);
        push_exp(0, 2, 5, 50, 1);
        drive();
        n = 0;
        while (acc_cnt[2] < 2 && n < 20) begin
            step();
            n++;
        end
        chk(0, "rst_reach_beat2", 64'(acc_cnt[2]), 64'd2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        src_q[2].delete();
        drive();
        chk(0, "rst_ovalid", 64'(ovalid[0]), 64'd0);
        chk(0, "rst_busy", 64'(busy[0]), 64'd0);
        chk(0, "rst_grant", 64'(grant[0]), 64'd0);
        chk(0, "rst_prefix_seen", 64'(exp_q[0].size()), 64'd0);
        load_src(0, 3, 2, 60);
        load_src(0, 0, 2, 61);
        push_exp(0, 0, 2, 61, 2);
        push_exp(0, 3, 2, 60, 2);
        drive();
        wait_drain(0, 50, "post_rst_drain");

        for (int d = 0; d < ND; d++) chk(d, "final_exp_empty", 64'(exp_q[d].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
